// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard/forwarding unit.
//   FWD_*      : encodings of the EX operand-mux Choose select
//   stage_t    : metadata of the instruction sitting in EX (rd, RegWrite, MemRead)
//   dest_t     : metadata of the instructions sitting in MEM and WB (rd, RegWrite)
//   BUBBLE     : stage_t value of an inserted bubble
//   DEST_EMPTY : dest_t value of a bubble in MEM/WB
package hazard_pkg;

  // Internal register-address width. Top-level RA_W must not exceed it;
  // narrower addresses are zero-extended on entry.
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_t;

  // Once a load has left EX its data is forwardable like any other result,
  // so MEM and WB only need to know who writes what.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } dest_t;

  localparam stage_t BUBBLE     = '{rd: '0, reg_write: 1'b0, mem_read: 1'b0};
  localparam dest_t  DEST_EMPTY = '{rd: '0, reg_write: 1'b0};

  // MEM holds the youngest producer, so it wins over WB.
  function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: one source-vs-destination register comparison.
//   src     : source register address
//   src_use : the consumer really reads src
//   dst     : destination register address of a producer
//   dst_en  : the producer qualifies (writes the RF, or is a load for stall checks)
//   hit     : dependency exists; x0 never matches
module hazard_match
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_use,
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic                  dst_en,
  output logic                  hit
);

  assign hit = src_use && dst_en && (dst != '0) && (src == dst);

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding selects, load-use stall and event counters
// for a 5-stage pipeline, driven from a private shadow of EX/MEM/WB metadata.
//   clk, rst                 : clock, asynchronous active-high reset
//   IdRs1/IdRs2, IdUseRs1/2  : ID source registers and whether they are read
//   IdRd, IdRegWrite         : ID destination register and write enable
//   IdMemRead                : ID instruction is a load
//   Flush                    : taken branch/jump resolved in EX this cycle
//   ForwardA/ForwardB        : Choose selects for the EX operand muxes
//   Stall                    : hold PC and IF/ID, bubble into EX
//   StallCount/FlushCount    : saturating event counters
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  IdRs1,
  input  logic [RA_W-1:0]  IdRs2,
  input  logic             IdUseRs1,
  input  logic             IdUseRs2,
  input  logic [RA_W-1:0]  IdRd,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             Flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  stage_t                ex_st;
  dest_t                 mem_st, wb_st;

  logic mem_a, mem_b, wb_a, wb_b, ld_a, ld_b;

  always_comb begin
    id_rs1 = '0;
    id_rs2 = '0;
    id_rd  = '0;
    id_rs1[RA_W-1:0] = IdRs1;
    id_rs2[RA_W-1:0] = IdRs2;
    id_rd[RA_W-1:0]  = IdRd;
  end

  // Shadow pipeline. Unused source fields are captured as x0 so they can
  // never produce a forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_st  <= BUBBLE;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      mem_st <= DEST_EMPTY;
      wb_st  <= DEST_EMPTY;
    end else begin
      mem_st <= '{rd: ex_st.rd, reg_write: ex_st.reg_write};
      wb_st  <= mem_st;
      if (Flush || Stall) begin
        ex_st  <= BUBBLE;
        ex_rs1 <= '0;
        ex_rs2 <= '0;
      end else begin
        ex_st  <= '{rd: id_rd, reg_write: IdRegWrite, mem_read: IdMemRead};
        ex_rs1 <= IdUseRs1 ? id_rs1 : '0;
        ex_rs2 <= IdUseRs2 ? id_rs2 : '0;
      end
    end
  end

  hazard_match u_mem_a (.src(ex_rs1), .src_use(1'b1), .dst(mem_st.rd),
                        .dst_en(mem_st.reg_write), .hit(mem_a));
  hazard_match u_mem_b (.src(ex_rs2), .src_use(1'b1), .dst(mem_st.rd),
                        .dst_en(mem_st.reg_write), .hit(mem_b));
  hazard_match u_wb_a  (.src(ex_rs1), .src_use(1'b1), .dst(wb_st.rd),
                        .dst_en(wb_st.reg_write), .hit(wb_a));
  hazard_match u_wb_b  (.src(ex_rs2), .src_use(1'b1), .dst(wb_st.rd),
                        .dst_en(wb_st.reg_write), .hit(wb_b));

  // Load-use: the load in EX cannot supply its data to the ID consumer in time.
  hazard_match u_ld_a  (.src(id_rs1), .src_use(IdUseRs1), .dst(ex_st.rd),
                        .dst_en(ex_st.mem_read), .hit(ld_a));
  hazard_match u_ld_b  (.src(id_rs2), .src_use(IdUseRs2), .dst(ex_st.rd),
                        .dst_en(ex_st.mem_read), .hit(ld_b));

  assign ForwardA = fwd_select(mem_a, wb_a);
  assign ForwardB = fwd_select(mem_b, wb_b);

  // A flush kills the ID instruction, so it overrides any load-use stall.
  assign Stall = !Flush && (ld_a || ld_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (Stall && (StallCount != '1)) StallCount <= StallCount + 1'b1;
      if (Flush && (FlushCount != '1)) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scoreboard bench for hazard_forward_unit.
// The driver places one ID instruction per cycle (1 time unit after the rising
// edge) and pushes the values it expects the DUT to show during that same
// cycle. The monitor samples on the falling edge and retires every expected
// entry tagged with the current cycle. Entry layout:
// {cycle[15:0], kind[15:0], value[31:0]}.
module tb_hazard_forward_unit;

  localparam int W = 64;

  localparam int K_FWDA  = 0;
  localparam int K_FWDB  = 1;
  localparam int K_STALL = 2;
  localparam int K_SCNT  = 3;
  localparam int K_FCNT  = 4;
  localparam int K_FCNT4 = 5;
  localparam int K_SCNT4 = 6;
  localparam int K_EXBSY = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use1 = 1'b0, id_use2 = 1'b0, id_rw = 1'b0, id_mr = 1'b0, flush = 1'b0;
  logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
  logic        stall, stall4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  hazard_forward_unit #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .IdRs1(id_rs1), .IdRs2(id_rs2),
    .IdUseRs1(id_use1), .IdUseRs2(id_use2), .IdRd(id_rd),
    .IdRegWrite(id_rw), .IdMemRead(id_mr), .Flush(flush),
    .ForwardA(fwd_a), .ForwardB(fwd_b), .Stall(stall),
    .StallCount(stall_cnt), .FlushCount(flush_cnt)
  );

  hazard_forward_unit #(.RA_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .IdRs1(id_rs1), .IdRs2(id_rs2),
    .IdUseRs1(id_use1), .IdUseRs2(id_use2), .IdRd(id_rd),
    .IdRegWrite(id_rw), .IdMemRead(id_mr), .Flush(flush),
    .ForwardA(fwd_a4), .ForwardB(fwd_b4), .Stall(stall4),
    .StallCount(stall_cnt4), .FlushCount(flush_cnt4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  function automatic string kind_name(input int k);
    case (k)
      K_FWDA:  return "ForwardA";
      K_FWDB:  return "ForwardB";
      K_STALL: return "Stall";
      K_SCNT:  return "StallCount";
      K_FCNT:  return "FlushCount";
      K_FCNT4: return "FlushCount_w4";
      K_SCNT4: return "StallCount_w4";
      K_EXBSY: return "ex_not_bubble";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_FWDA:  return {30'b0, fwd_a};
      K_FWDB:  return {30'b0, fwd_b};
      K_STALL: return {31'b0, stall};
      K_SCNT:  return stall_cnt;
      K_FCNT:  return flush_cnt;
      K_FCNT4: return {28'b0, flush_cnt4};
      K_SCNT4: return {28'b0, stall_cnt4};
      K_EXBSY: return {30'b0, dut.ex_st.reg_write, dut.ex_st.mem_read};
      default: return 32'hdead_beef;
    endcase
  endfunction

  // monitor
  logic [W-1:0] ent;
  logic [31:0]  act;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][63:48] <= cyc[15:0]) begin
      ent = exp_q.pop_front();
      checks++;
      if (ent[63:48] != cyc[15:0]) begin
        $display("FAIL stale_%s cycle %0d: not sampled, now cycle %0d",
                 kind_name(int'(ent[47:32])), ent[63:48], cyc);
      end else begin
        act = actual(int'(ent[47:32]));
        if (act == ent[31:0]) passed++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d",
                      kind_name(int'(ent[47:32])), cyc, act, ent[31:0]);
      end
    end
  end

  // driver tasks
  task automatic expect_now(input int kind, input logic [31:0] val);
    logic [15:0] c;
    logic [15:0] k;
    c = cyc[15:0];
    k = kind[15:0];
    exp_q.push_back({c, k, val});
  endtask

  task automatic expect_fwd(input logic [1:0] a, input logic [1:0] b, input logic s);
    expect_now(K_FWDA, {30'b0, a});
    expect_now(K_FWDB, {30'b0, b});
    expect_now(K_STALL, {31'b0, s});
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic fl);
    @(posedge clk);
    #1;
    id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_rd = rd; id_rw = rw; id_mr = mr; flush = fl;
  endtask

  task automatic nop();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    expect_fwd(2'b00, 2'b00, 1'b0);
    expect_now(K_SCNT, 0);
    expect_now(K_FCNT, 0);
    expect_now(K_FCNT4, 0);
    expect_now(K_SCNT4, 0);
    rst = 1'b0;
    nops(3);

    // back-to-back ALU dependency: add x5,x1,x2 ; sub x6,x5,x3
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(5'd5, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    expect_fwd(2'b00, 2'b00, 1'b0);
    nop();
    expect_fwd(2'b01, 2'b00, 1'b0);
    nops(3);

    // priority: two writers of x5, then a reader of x5 on rs2
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    issue(5'd9, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    expect_fwd(2'b00, 2'b01, 1'b0);
    nops(3);
    // single writer two instructions back
    issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    nop();
    issue(5'd9, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    expect_fwd(2'b00, 2'b10, 1'b0);
    nops(3);

    // load-use on rs1: lw x7,0(x1) ; add x9,x7,x2
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_fwd(2'b00, 2'b00, 1'b1);
    issue(5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);  // held by stall
    expect_fwd(2'b00, 2'b00, 1'b0);
    expect_now(K_EXBSY, 0);
    expect_now(K_SCNT, 1);
    nop();
    expect_fwd(2'b10, 2'b00, 1'b0);
    expect_now(K_SCNT, 1);
    nops(3);

    // x0 load never stalls or forwards
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_now(K_STALL, 0);
    nop();
    expect_fwd(2'b00, 2'b00, 1'b0);
    nops(3);

    // unused rs2 matching the load: no stall, no forward
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    issue(5'd3, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_now(K_STALL, 0);
    nop();
    expect_fwd(2'b00, 2'b00, 1'b0);
    nops(3);

    // load-use on rs2
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    issue(5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_now(K_STALL, 1);
    issue(5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_now(K_STALL, 0);
    nop();
    expect_fwd(2'b00, 2'b10, 1'b0);
    expect_now(K_SCNT, 2);
    nops(3);

    // flush beats stall
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    expect_now(K_STALL, 0);
    expect_now(K_FCNT, 0);
    nop();
    expect_now(K_EXBSY, 0);
    expect_now(K_FCNT, 1);
    expect_now(K_SCNT, 2);
    expect_now(K_FCNT4, 1);
    nops(3);

    // reset in the middle of a stall
    issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    issue(5'd7, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    expect_now(K_STALL, 1);
    expect_now(K_SCNT, 2);
    expect_now(K_FCNT, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_fwd(2'b00, 2'b00, 1'b0);
    expect_now(K_SCNT, 0);
    expect_now(K_FCNT, 0);
    expect_now(K_FCNT4, 0);
    expect_now(K_SCNT4, 0);
    expect_now(K_EXBSY, 0);
    rst = 1'b0;
    nop();

    // saturation: 20 flushes into a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      if (k == 10) expect_now(K_FCNT4, 10);
    end
    nop();
    expect_now(K_FCNT4, 15);
    expect_now(K_FCNT, 20);
    expect_now(K_SCNT, 0);
    nops(2);

    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      checks++;
      $display("FAIL unchecked_%s cycle %0d: never sampled", kind_name(int'(ent[47:32])), ent[63:48]);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
